// File: rtl/neuron_state_unit_if.sv
// Handshake bundle between the neuron state unit and the downstream accumulate stage.
// master = state unit (issues decayed potentials), slave = accumulate stage (returns writebacks).
interface neuron_state_unit_if #(
   parameter int NEURONS = 16
) ();
   localparam int IDX_W = $clog2(NEURONS);

   logic                    dec_valid;
   logic                    dec_ready;
   logic [IDX_W-1:0]        neuron_id;
   logic signed [31:0]      decayed_potential;
   logic                    wb_valid;
   logic signed [31:0]      potential_to_mem;
   logic                    spiked;

   modport master (
      output dec_valid,
      output neuron_id,
      output decayed_potential,
      input  dec_ready,
      input  wb_valid,
      input  potential_to_mem,
      input  spiked
   );

   modport slave (
      input  dec_valid,
      input  neuron_id,
      input  decayed_potential,
      output dec_ready,
      output wb_valid,
      output potential_to_mem,
      output spiked
   );
endinterface

// File: rtl/neuron_state_unit.sv
// Neuron membrane-potential store and timestep sweep sequencer.
// Build option: define NEURON_LEAK_EN to apply p - (p >>> DECAY_SHIFT) on issue; otherwise potentials pass through.
//
//  state   | meaning
//  IDLE    | waiting for timestep_start
//  ISSUE   | presenting neuron idx to the accumulate stage (dec_valid=1)
//  WAIT_WB | pair accepted, waiting for the writeback of neuron idx
//  DONE    | sweep finished, done pulse, spike_vec holds this timestep's spikes
module neuron_state_unit #(
   parameter int NEURONS     = 16,
   parameter int DECAY_SHIFT = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     timestep_start,
   neuron_state_unit_if.master      bus,
   output logic [NEURONS-1:0]       spike_vec,
   output logic                     busy,
   output logic                     done
);
   localparam int IDX_W = $clog2(NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

   if (DECAY_SHIFT < 1 || DECAY_SHIFT > 31 || NEURONS < 2 || NEURONS > 256) begin : g_bad_param
      $error("neuron_state_unit: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_WB = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NEURONS-1:0]     work_q, work_d;
   logic [NEURONS-1:0]     spike_vec_q, spike_vec_d;
   logic signed [31:0]     mem_q [NEURONS];
   logic signed [31:0]     mem_d [NEURONS];
   logic                   dec_valid_q, dec_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic signed [31:0]     cur_pot;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      work_d      = work_q;
      spike_vec_d = spike_vec_q;
      mem_d       = mem_q;

      case (state_q)
         IDLE: begin
            if (timestep_start) begin
               state_d = ISSUE;
               idx_d   = '0;
               work_d  = '0;
            end
         end
         ISSUE: begin
            if (bus.dec_ready) state_d = WAIT_WB;
         end
         WAIT_WB: begin
            if (bus.wb_valid) begin
               mem_d[idx_q]  = bus.potential_to_mem;
               work_d[idx_q] = bus.spiked;
               if (idx_q == LAST_IDX) begin
                  state_d     = DONE;
                  // Publish together with the done pulse so consumers see both in the same cycle.
                  spike_vec_d = work_d;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      dec_valid_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         work_q      <= '0;
         spike_vec_q <= '0;
         dec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < NEURONS; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         work_q      <= work_d;
         spike_vec_q <= spike_vec_d;
         dec_valid_q <= dec_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         for (int i = 0; i < NEURONS; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign cur_pot = mem_q[idx_q];

`ifdef NEURON_LEAK_EN
   logic signed [31:0] leak;
   assign leak                  = cur_pot >>> DECAY_SHIFT;
   assign bus.decayed_potential = cur_pot - leak;
`else
   assign bus.decayed_potential = cur_pot;
`endif

   assign bus.dec_valid = dec_valid_q;
   assign bus.neuron_id = idx_q;
   assign spike_vec     = spike_vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_neuron_state_unit.sv
// Self-checking bench for neuron_state_unit: randomized sweeps against a potential/spike array model.
module tb_neuron_state_unit;
   localparam int N  = 16;
   localparam int DS = 3;

   logic          clk;
   logic          reset_n;
   logic          timestep_start;
   logic [N-1:0]  spike_vec;
   logic          busy;
   logic          done;

   neuron_state_unit_if #(.NEURONS(N)) bus ();

   neuron_state_unit #(.NEURONS(N), .DECAY_SHIFT(DS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .timestep_start (timestep_start),
      .bus            (bus),
      .spike_vec      (spike_vec),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   int           mem_m    [N];
   logic [N-1:0] spk_m;
   int           pot_plan [N];
   logic [N-1:0] spk_plan;

   // Expected issue value: floor(p / 2^DS) leak subtracted, computed with plain division.
   function automatic int model_out(input int p);
`ifdef NEURON_LEAK_EN
      longint d, q, pl;
      d  = longint'(1) << DS;
      pl = longint'(p);
      q  = (pl >= 0) ? (pl / d) : -((-pl + d - 1) / d);
      return int'(pl - q);
`else
      return p;
`endif
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full sweep; stall_at/abort_at = -1 disables stalling / mid-sweep reset.
   task automatic sweep(input int stall_at, input int stall_n, input bit noise, input int abort_at);
      int d0;
      int wait_k;
      logic signed [31:0] held_data;
      d0 = done_cnt;
      total++;
      if (bus.dec_valid !== 1'b0) begin
         bad++; $display("FAIL idle_dec_valid got=%b want=0", bus.dec_valid);
      end
      timestep_start = 1'b1;
      step();
      timestep_start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL busy_after_start got=%b want=1", busy);
      end
      for (int n = 0; n < N; n++) begin
         wait_k = 0;
         while (bus.dec_valid !== 1'b1 && wait_k < 20) begin
            step();
            wait_k++;
         end
         total++;
         if (bus.dec_valid !== 1'b1) begin
            bad++; $display("FAIL issue_timeout neuron=%0d got dec_valid=%b want=1", n, bus.dec_valid);
            return;
         end
         if (n == abort_at) begin
            reset_n = 1'b0;
            #1;
            total++;
            if (busy !== 1'b0 || bus.dec_valid !== 1'b0 || done !== 1'b0) begin
               bad++; $display("FAIL abort_outputs got busy=%b valid=%b done=%b want 0/0/0", busy, bus.dec_valid, done);
            end
            for (int i = 0; i < N; i++) mem_m[i] = 0;
            spk_m = '0;
            step();
            reset_n = 1'b1;
            step();
            total++;
            if (done_cnt != d0 || spike_vec !== spk_m) begin
               bad++; $display("FAIL abort_no_done got done_cnt=%0d spike_vec=%h want %0d/%h", done_cnt, spike_vec, d0, spk_m);
            end
            return;
         end
         total++;
         if (bus.neuron_id !== 4'(n)) begin
            bad++; $display("FAIL neuron_id got=%0d want=%0d", bus.neuron_id, n);
         end
         total++;
         if (bus.decayed_potential !== model_out(mem_m[n])) begin
            bad++; $display("FAIL decayed n=%0d got=%0d want=%0d", n, bus.decayed_potential, model_out(mem_m[n]));
         end
         total++;
         if (spike_vec !== spk_m) begin
            bad++; $display("FAIL spike_vec_hold got=%h want=%h", spike_vec, spk_m);
         end
         if (n == stall_at) begin
            held_data = bus.decayed_potential;
            for (int k = 0; k < stall_n; k++) begin
               if (noise) begin
                  bus.wb_valid         = 1'b1;
                  bus.potential_to_mem = 32'(int'($urandom));
                  bus.spiked           = 1'b1;
                  timestep_start       = 1'b1;
               end
               step();
               total++;
               if (bus.dec_valid !== 1'b1 || bus.neuron_id !== 4'(n) || bus.decayed_potential !== held_data) begin
                  bad++; $display("FAIL stall_stable got valid=%b id=%0d data=%0d want 1/%0d/%0d",
                                  bus.dec_valid, bus.neuron_id, bus.decayed_potential, n, held_data);
               end
            end
            bus.wb_valid   = 1'b0;
            bus.spiked     = 1'b0;
            timestep_start = 1'b0;
         end
         bus.dec_ready = 1'b1;
         step();
         bus.dec_ready = 1'b0;
         total++;
         if (bus.dec_valid !== 1'b0) begin
            bad++; $display("FAIL valid_after_hs got=%b want=0", bus.dec_valid);
         end
         repeat ($urandom_range(0, 2)) step();
         bus.wb_valid         = 1'b1;
         bus.potential_to_mem = 32'(pot_plan[n]);
         bus.spiked           = spk_plan[n];
         step();
         bus.wb_valid = 1'b0;
         bus.spiked   = 1'b0;
         mem_m[n] = pot_plan[n];
      end
      spk_m = spk_plan;
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL done_pulse got=%b want=1", done);
      end
      total++;
      if (spike_vec !== spk_m) begin
         bad++; $display("FAIL spike_vec got=%h want=%h", spike_vec, spk_m);
      end
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || done_cnt != d0 + 1) begin
         bad++; $display("FAIL done_one_cycle got done=%b busy=%b pulses=%0d want 0/0/%0d", done, busy, done_cnt - d0, 1);
      end
   endtask

   task automatic plan_random;
      for (int i = 0; i < N; i++) pot_plan[i] = int'($urandom);
      spk_plan = N'($urandom);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.dec_valid !== 1'b0 || spike_vec !== '0) begin
         bad++; $display("FAIL reset_state got busy=%b done=%b valid=%b spk=%h want all 0", busy, done, bus.dec_valid, spike_vec);
      end
      reset_n = 1'b1;
      step();
      for (int i = 0; i < N; i++) mem_m[i] = 0;
      spk_m = '0;
   endtask

   task automatic test_zero_sweep;
      for (int i = 0; i < N; i++) pot_plan[i] = 0;
      spk_plan = '0;
      sweep(-1, 0, 1'b0, -1);
   endtask

   task automatic test_leak;
      pot_plan[0] = 100;
      sweep(-1, 0, 1'b0, -1);
      pot_plan[0] = -100;
      sweep(-1, 0, 1'b0, -1);
      pot_plan[0] = 0;
      sweep(-1, 0, 1'b0, -1);
   endtask

   task automatic test_spikes;
      plan_random();
      spk_plan = 16'h8008;
      sweep(-1, 0, 1'b0, -1);
      plan_random();
      sweep(-1, 0, 1'b0, -1);
   endtask

   task automatic test_stall;
      plan_random();
      sweep(5, 5, 1'b0, -1);
   endtask

   task automatic test_ignore;
      plan_random();
      sweep(9, 4, 1'b1, -1);
      plan_random();
      sweep(0, 3, 1'b1, -1);
   endtask

   task automatic test_mid_reset;
      plan_random();
      sweep(-1, 0, 1'b0, 7);
      plan_random();
      sweep(-1, 0, 1'b0, -1);
   endtask

   task automatic test_random;
      for (int r = 0; r < 4; r++) begin
         plan_random();
         sweep(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), 1'(r & 1), -1);
      end
   endtask

   initial begin
      timestep_start       = 1'b0;
      bus.dec_ready        = 1'b0;
      bus.wb_valid         = 1'b0;
      bus.potential_to_mem = '0;
      bus.spiked           = 1'b0;
      reset_n              = 1'b0;
      spk_m                = '0;
      spk_plan             = '0;
      for (int i = 0; i < N; i++) begin
         mem_m[i]    = 0;
         pot_plan[i] = 0;
      end
      #1;
      test_reset();
      test_zero_sweep();
      test_leak();
      test_spikes();
      test_stall();
      test_ignore();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/neuron_state_unit.md
NEURON_STATE_UNIT -- requirements
Module: neuron_state_unit

Interface
REQ-001 SHALL have parameter NEURONS, default 16, number of neurons held (power of two, 2..256).
REQ-002 SHALL have parameter DECAY_SHIFT, default 3, leak shift amount (1..31).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port timestep_start, input, 1: one-cycle pulse that begins a timestep sweep.
REQ-006 SHALL have port dec_valid, output, 1: the neuron_id/decayed_potential pair is valid.
REQ-007 SHALL have port dec_ready, input, 1: the downstream accumulate stage accepts the pair.
REQ-008 SHALL have port neuron_id, output, log2(NEURONS): index of the neuron being processed.
REQ-009 SHALL have port decayed_potential, output, 32: signed leaked potential sent to the accumulate stage.
REQ-010 SHALL have port wb_valid, input, 1: writeback strobe from the accumulate stage.
REQ-011 SHALL have port potential_to_mem, input, 32: signed post-reset potential to store.
REQ-012 SHALL have port spiked, input, 1: spike flag for the neuron being written back.
REQ-013 SHALL have port spike_vec, output, NEURONS: spikes of the last completed timestep; bit i is neuron i.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a sweep completes.

Function
REQ-016 SHALL hold NEURONS x 32-bit signed potentials in internal registers, with index counter idx.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_WB and DONE.
REQ-018 SHALL move IDLE->ISSUE on timestep_start, set idx=0 and clear the working spike register; start is ignored in any other state.
REQ-019 SHALL in ISSUE drive dec_valid=1, neuron_id=idx and decayed_potential=decay(mem[idx]), holding them stable until dec_ready=1.
REQ-020 SHALL move ISSUE->WAIT_WB on the edge where dec_valid and dec_ready are both 1, after which dec_valid=0.
REQ-021 SHALL in WAIT_WB, on wb_valid=1, write mem[idx]=potential_to_mem and set working spike bit idx=spiked.
REQ-022 SHALL after that writeback go to DONE if idx==NEURONS-1, otherwise increment idx and return to ISSUE.
REQ-023 SHALL ignore wb_valid in every state except WAIT_WB; it SHALL allow wb_valid in the cycle right after the handshake.
REQ-024 SHALL in DONE copy the working register to spike_vec and assert done for exactly one cycle, then go to IDLE.
REQ-025 SHALL assert dec_valid no earlier than the cycle after timestep_start (minimum one-cycle latency).
REQ-026 SHALL, with leak enabled, compute decay(p) = p - (p >>> DECAY_SHIFT) as signed 32-bit with arithmetic shift and no saturation.
REQ-027 SHALL keep spike_vec unchanged from one DONE to the next.

Reset
REQ-028 SHALL, while reset_n=0, clear all potentials, idx, the working register and spike_vec to 0, hold dec_valid/busy/done at 0, and put the FSM in IDLE.
REQ-029 SHALL, on reset in the middle of a sweep, abandon the sweep with no done pulse and keep partially written potentials cleared.

Configuration
REQ-030 SHALL use macro NEURON_LEAK_EN: defined gives decayed_potential = decay(mem[idx]); undefined gives decayed_potential = mem[idx] (no leak, DECAY_SHIFT unused).

Verification
REQ-031 Reset, then timestep_start with dec_ready=1 and each writeback returning 0/spiked=0 -> 16 issues with neuron_id 0..15, done pulse, spike_vec=0.
REQ-032 Leak enabled, mem[0]=100, then sweep -> decayed_potential=88 for neuron 0; mem[0]=-100 -> -87.
REQ-033 Hold dec_ready=0 for 5 cycles in ISSUE -> dec_valid, neuron_id and decayed_potential stay stable; FSM advances only after dec_ready=1.
REQ-034 Writebacks with spiked=1 for neurons 3 and 15 -> after done, spike_vec=16'h8008, and spike_vec does not change during the next sweep until its done.
REQ-035 Pulse timestep_start while busy, and pulse wb_valid while in ISSUE -> both are ignored; sweep order and stored values are unchanged.
REQ-036 Assert reset_n=0 while at neuron 7 -> busy=0 immediately, no done pulse, all potentials read back as 0 in the next sweep.
